// File: rtl/dmem_sized_handshake.sv
// dmem_sized_handshake: byte-addressed, big-endian data memory behind a
// valid/ready request port with a fixed response latency. After reset the
// array is filled with a repeating two-word pattern, one word per cycle.
// Byte, half and word accesses are supported; misaligned and out-of-range
// accesses return an error response and leave memory untouched.
// Optional build macro: DMEM_SIGN_EXT_EN adds req_signed so that byte and
// half loads can be sign-extended; without it all loads zero-extend.
module dmem_sized_handshake #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] INIT_WORD0  = 32'h011C04EE,
  parameter logic [31:0] INIT_WORD1  = 32'h3142DFCC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_SIGN_EXT_EN
  input  logic        req_signed,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int unsigned AW     = $clog2(DEPTH_BYTES);
  localparam int unsigned PW     = AW - 2;
  localparam int unsigned NWORDS = DEPTH_BYTES / 4;
  localparam logic [PW-1:0] PTR_LAST = PW'(NWORDS - 1);
  localparam logic [2:0]    CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] nb;
    case (size)
      2'b00:   nb = 3'd1;
      2'b01:   nb = 3'd2;
      2'b10:   nb = 3'd4;
      default: nb = 3'd4;
    endcase
    return nb;
  endfunction

  // Alignment, size-code and range check. The end address is formed in
  // 33 bits so addresses near 2^32 cannot wrap back into range.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic        bad;
    logic [32:0] end_addr;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
    if (end_addr > 33'(DEPTH_BYTES)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  logic [7:0]    mem_q [DEPTH_BYTES];

  state_e        state_q,     state_d;
  logic [PW-1:0] ptr_q,       ptr_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic          we_q,        we_d;
  logic [1:0]    size_q,      size_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic [31:0]   wdata_q,     wdata_d;
  logic          err_q,       err_d;
  logic          sgn_q,       sgn_d;
  logic          ready_q,     ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q,     rdata_d;
  logic          rsp_err_q,   rsp_err_d;
  logic          init_done_q, init_done_d;

  logic          resp_cycle_s;
  logic          commit_s;
  logic [7:0]    rd_b0_s, rd_b1_s, rd_b2_s, rd_b3_s;
  logic [31:0]   load_data_s;
  logic [3:0]    wen_s;
  logic [AW-1:0] widx_s  [4];
  logic [7:0]    wbyte_s [4];

  assign resp_cycle_s = (state_q == S_WAIT) && (cnt_q == 3'd0);
  assign commit_s     = resp_cycle_s && we_q && !err_q;

  assign rd_b0_s = mem_q[addr_q];
  assign rd_b1_s = mem_q[addr_q + AW'(1)];
  assign rd_b2_s = mem_q[addr_q + AW'(2)];
  assign rd_b3_s = mem_q[addr_q + AW'(3)];

  // Right-align the loaded bytes (big-endian) and extend to 32 bits.
  always_comb begin
    load_data_s = 32'd0;
    case (size_q)
      2'b00:   load_data_s = {{24{sgn_q & rd_b0_s[7]}}, rd_b0_s};
      2'b01:   load_data_s = {{16{sgn_q & rd_b0_s[7]}}, rd_b0_s, rd_b1_s};
      2'b10:   load_data_s = {rd_b0_s, rd_b1_s, rd_b2_s, rd_b3_s};
      default: load_data_s = 32'd0;
    endcase
  end

  // Byte-lane write requests: pattern fill during INIT, store commit on
  // the response cycle; lane k always targets base+k.
  always_comb begin
    wen_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      widx_s[k]  = addr_q + AW'(k);
      wbyte_s[k] = 8'd0;
    end
    if (state_q == S_INIT) begin
      wen_s = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        widx_s[k]  = {ptr_q, 2'b00} + AW'(k);
        wbyte_s[k] = ptr_q[0] ? INIT_WORD1[8*(3-k) +: 8] : INIT_WORD0[8*(3-k) +: 8];
      end
    end else if (commit_s) begin
      case (size_q)
        2'b00: begin
          wen_s      = 4'b0001;
          wbyte_s[0] = wdata_q[7:0];
        end
        2'b01: begin
          wen_s      = 4'b0011;
          wbyte_s[0] = wdata_q[15:8];
          wbyte_s[1] = wdata_q[7:0];
        end
        2'b10: begin
          wen_s      = 4'b1111;
          wbyte_s[0] = wdata_q[31:24];
          wbyte_s[1] = wdata_q[23:16];
          wbyte_s[2] = wdata_q[15:8];
          wbyte_s[3] = wdata_q[7:0];
        end
        default: wen_s = 4'b0000;
      endcase
    end else begin
      wen_s = 4'b0000;
    end
  end

  // Memory array: un-reset storage, up to four byte lanes per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wen_s[k]) begin
        mem_q[widx_s[k]] <= wbyte_s[k];
      end
    end
  end

  // Next-state and next-output logic for the INIT/IDLE/WAIT controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    sgn_d       = sgn_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rsp_err_d   = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        if (ptr_q == PTR_LAST) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          ready_d     = 1'b1;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          err_d   = access_err(req_size, req_addr);
`ifdef DMEM_SIGN_EXT_EN
          sgn_d   = req_signed;
`else
          sgn_d   = 1'b0;
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = S_IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rdata_d     = (err_q || we_q) ? 32'd0 : load_data_s;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Controller state and registered outputs; reset restarts the fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      sgn_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      sgn_q       <= sgn_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_dmem_sized_handshake.sv
// Bench for dmem_sized_handshake: directed vector table, hand-written reset
// and timing sequences, and random traffic against a byte-array model.
module tb_dmem_sized_handshake;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [31:0] W0    = 32'h011C04EE;
  localparam logic [31:0] W1    = 32'h3142DFCC;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_signed;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  dmem_sized_handshake #(
    .DEPTH_BYTES(DEPTH),
    .LATENCY    (LAT),
    .INIT_WORD0 (W0),
    .INIT_WORD1 (W1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_SIGN_EXT_EN
    .req_signed(req_signed),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the whole array holds the alternating two-word pattern.
  task automatic ref_fill();
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = ((i / 4) % 2 == 1) ? W1 : W0;
      ref_mem[i] = w[8*(3 - (i % 4)) +: 8];
    end
  endtask

  // Model: apply one access to the byte array, return the expected response.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic sgn,
                        output logic [31:0] rd, output logic err);
    int nb;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (64'(addr) + 64'(nb) > 64'(DEPTH));
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) ref_mem[addr + k] = 8'(wdata >> (8 * (nb - 1 - k)));
      end else begin
        v = 32'd0;
        for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[addr + k]);
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
        rd = v;
      end
    end
  endtask

  // Issue one request and check handshake timing and the response.
  task automatic xact(input string name, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic sgn,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_signed = sgn;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      check({name, "_ready_low"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(LAT));
    check({name, "_rdata"}, rsp_rdata, exp_rd);
    check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({name, "_ready_back"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    check({name, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({name, "_err_clear"}, 32'(rsp_err), 32'd0);
    check({name, "_rdata_hold"}, rsp_rdata, exp_rd);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 32'(req_ready), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rdata"}, rsp_rdata, 32'd0);
    check({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({name, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  // Release reset on a falling edge and check the fill takes DEPTH/4 cycles.
  task automatic release_and_init(input string name);
    @(negedge clk);
    reset = 1'b0;
    repeat (DEPTH / 4 - 1) @(negedge clk);
    check({name, "_init_not_yet"}, 32'(init_done), 32'd0);
    check({name, "_ready_not_yet"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({name, "_init_done"}, 32'(init_done), 32'd1);
    check({name, "_ready_up"}, 32'(req_ready), 32'd1);
    ref_fill();
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        sg;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_signed = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    release_and_init("init");

    vecs.push_back(mk(1'b0, 2'd2, 32'd0,          32'd0,        32'h011C04EE, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd4,          32'd0,        32'h3142DFCC, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 32'd7,          32'd0,        32'h000000CC, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2, 32'd16,         32'hAABBCCDD, 32'd0,        1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 32'd18,         32'h00001234, 32'd0,        1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd16,         32'd0,        32'hAABB1234, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 32'd17,         32'd0,        32'h000000BB, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd2,          32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b1, 2'd1, 32'd5,          32'h0000FFFF, 32'd0,        1'b1));
    vecs.push_back(mk(1'b0, 2'd0, 32'd256,        32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b1, 2'd3, 32'd0,          32'hFFFFFFFF, 32'd0,        1'b1));
    vecs.push_back(mk(1'b0, 2'd2, 32'd0,          32'd0,        32'h011C04EE, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd4,          32'd0,        32'h3142DFCC, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd252,        32'd0,        32'h3142DFCC, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 32'd254,        32'd0,        32'h0000DFCC, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd253,        32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b0, 2'd1, 32'd255,        32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b0, 2'd1, 32'd256,        32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b0, 2'd2, 32'hFFFFFFFC,   32'd0,        32'd0,        1'b1));
    vecs.push_back(mk(1'b1, 2'd0, 32'd255,        32'h0000005A, 32'd0,        1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 32'd252,        32'd0,        32'h3142DF5A, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 32'd0,          32'd0,        32'h00000001, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 32'd2,          32'd0,        32'h000004EE, 1'b0));

    foreach (vecs[i]) begin
      xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
           1'b0, vecs[i].exp_rd, vecs[i].exp_err);
      ref_op(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er);
    end

    // Reset while a store to address 8 is waiting for its response.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'd8; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    release_and_init("reinit");
    xact("after_reset_lw8", 1'b0, 2'd2, 32'd8, 32'd0, 1'b0, W0, 1'b0);
    xact("after_reset_lw16", 1'b0, 2'd2, 32'd16, 32'd0, 1'b0, W0, 1'b0);

`ifdef DMEM_SIGN_EXT_EN
    xact("sx_lb2",  1'b0, 2'd0, 32'd2, 32'd0, 1'b1, 32'h00000004, 1'b0);
    xact("sx_lb3",  1'b0, 2'd0, 32'd3, 32'd0, 1'b1, 32'hFFFFFFEE, 1'b0);
    xact("sx_lh6",  1'b0, 2'd1, 32'd6, 32'd0, 1'b1, 32'hFFFFDFCC, 1'b0);
    xact("zx_lh6",  1'b0, 2'd1, 32'd6, 32'd0, 1'b0, 32'h0000DFCC, 1'b0);
    xact("sx_lw4",  1'b0, 2'd2, 32'd4, 32'd0, 1'b1, 32'h3142DFCC, 1'b0);
`else
    xact("zx_lb3",  1'b0, 2'd0, 32'd3, 32'd0, 1'b1, 32'h000000EE, 1'b0);
    xact("zx_lh6",  1'b0, 2'd1, 32'd6, 32'd0, 1'b1, 32'h0000DFCC, 1'b0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ad = $urandom;
      else ad = 32'($urandom_range(0, DEPTH + 3));
      wd = $urandom;
`ifdef DMEM_SIGN_EXT_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      ref_op(we, sz, ad, wd, sg, rd, er);
      xact($sformatf("rand%0d", i), we, sz, ad, wd, sg, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_sized_handshake.md
Name: dmem_sized_handshake

Overview:
- Parametrised byte-addressed, big-endian data memory for the MIPS datapath.
- Supports byte, halfword and word loads and stores over a valid/ready request port.
- Returns responses after a configurable fixed latency.
- Flags misaligned and out-of-range accesses.
- Self-initialises to a two-word test pattern after reset, one word per cycle.

Parameters:
- DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 8 and at least 8.
- LATENCY, 1, cycles from request accept to response; legal range 1..8.
- INIT_WORD0, 32'h011C04EE, pattern written at byte offsets 8k..8k+3.
- INIT_WORD1, 32'h3142DFCC, pattern written at byte offsets 8k+4..8k+7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data, right-aligned, zero-extended.
- rsp_err  out  1  access was rejected; valid only with rsp_valid.
- init_done  out  1  high once pattern initialisation completes.

Behaviour:
- Reset (async assert) forces state to INIT and init pointer to 0.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- Reset mid-operation aborts any in-flight request; no response is issued for it and the pattern fill restarts.
- FSM states: INIT, IDLE, WAIT.
- INIT:
  - Writes one word per cycle: INIT_WORD0 at even word index, INIT_WORD1 at odd word index.
  - Pointer runs 0..DEPTH_BYTES/4-1, taking DEPTH_BYTES/4 cycles.
  - Then goes to IDLE with init_done=1; init_done stays 1 until the next reset.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid and req_ready are both high at a rising edge.
  - On accept, latch we/size/addr/wdata and the error check result, then go to WAIT with counter=LATENCY-1.
- WAIT:
  - req_ready=0; only one request is outstanding at a time.
  - When counter==0, pulse rsp_valid for one cycle and return to IDLE. The response therefore appears exactly LATENCY cycles after the accept edge.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
- Error conditions:
  - Size 11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr+bytes > DEPTH_BYTES, computed in 33 bits so there is no wrap-around.
- On error: no memory update, rsp_rdata=0, rsp_err=1.
- Stores:
  - Committed on the response cycle.
  - Big-endian: byte at addr takes the most significant stored byte.
  - sb writes wdata[7:0] to addr.
  - sh writes wdata[15:8] to addr and wdata[7:0] to addr+1.
  - sw writes [31:24] to addr through [7:0] to addr+3.
  - Store responses have rsp_rdata=0.
- Loads:
  - Read on the response cycle, so they observe all prior stores.
  - lb returns {24'b0, M[a]}.
  - lh returns {16'b0, M[a], M[a+1]}.
  - lw returns {M[a], M[a+1], M[a+2], M[a+3]}.
- Between responses: rsp_rdata holds its last value and rsp_err returns to 0.
- Requests presented while req_ready=0 are ignored; the requester must hold them.

Optional Feature:
- Macro: DMEM_SIGN_EXT_EN.
- Defined:
  - Adds input req_signed (1 bit), latched on accept.
  - Byte and half loads with req_signed=1 sign-extend from bit 7 or bit 15 respectively.
  - req_signed is ignored for words and stores.
- Undefined:
  - The port is absent and all loads zero-extend.

Test Plan:
- Reset released, then wait DEPTH_BYTES/4 cycles -> init_done=1. lw addr 0 -> 32'h011C04EE; lw addr 4 -> 32'h3142DFCC; lb addr 7 -> 32'h000000CC.
- LATENCY=3: lw accepted at edge N -> rsp_valid high only in the cycle after edge N+3. req_ready low from N to N+3, high again after.
- sw 32'hAABBCCDD at 16, then sh 32'h00001234 at 18, then lw 16 -> 32'hAABB1234. lb 17 -> 32'h000000BB.
- lw addr 2, sh addr 5, lb addr DEPTH_BYTES, and size 11 -> each returns rsp_err=1 with rsp_rdata=0. A following lw of the affected word shows it unchanged.
- Assert reset during WAIT of a store to addr 8 -> no rsp_valid and no write; the fill reruns. lw 8 -> 32'h011C04EE.
- With DMEM_SIGN_EXT_EN: lb addr 2 signed -> 32'h00000004; lb addr 3 signed -> 32'hFFFFFFEE; lh addr 6 signed -> 32'hFFFFDFCC; lh addr 6 unsigned -> 32'h0000DFCC.
